// File: rtl/amp_modulator_mc.sv
// Multi-channel pipelined amplitude modulator: bypass / ring / AM / mute gain per beat,
// round-half-up and saturation per lane. Optional gain smoothing via `AMP_MOD_SMOOTH_EN.
module amp_modulator_mc #(
    parameter int DATA_WIDTH   = 16,
    parameter int MOD_WIDTH    = 16,
    parameter int FRAC_BITS    = 8,
    parameter int CHANNELS     = 2,
    parameter int DEPTH_WIDTH  = 8,
    parameter int SMOOTH_SHIFT = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [CHANNELS*DATA_WIDTH-1:0] signal_i,
    input  logic [MOD_WIDTH-1:0]           modulator_i,
    input  logic [1:0]                     mode_i,
    input  logic [DEPTH_WIDTH-1:0]         depth_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [CHANNELS*DATA_WIDTH-1:0] signal_o,
    output logic [CHANNELS-1:0]            clip_o
);

    localparam int GW = MOD_WIDTH + 2;
    localparam int PW = DATA_WIDTH + GW;
    localparam int AW = MOD_WIDTH + DEPTH_WIDTH + 1;
    localparam int SW = CHANNELS * DATA_WIDTH;

    localparam logic [1:0] MODE_BYPASS = 2'b00;
    localparam logic [1:0] MODE_RING   = 2'b01;
    localparam logic [1:0] MODE_AM     = 2'b10;
    localparam logic [1:0] MODE_MUTE   = 2'b11;

    localparam logic signed [GW-1:0] UNITY =
        {{(GW-FRAC_BITS-1){1'b0}}, 1'b1, {FRAC_BITS{1'b0}}};
    localparam logic signed [PW:0] RND_HALF =
        {{(PW-FRAC_BITS+1){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [PW:0] SAT_MAX =
        {{(PW-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] SAT_MIN =
        {{(PW-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic                        en_s;

    logic                        s1_valid_r;
    logic [SW-1:0]               s1_sig_r;
    logic signed [MOD_WIDTH-1:0] s1_mod_r;
    logic [1:0]                  s1_mode_r;
    logic [DEPTH_WIDTH-1:0]      s1_depth_r;

    logic signed [AW-1:0]        am_prod_s;
    logic signed [GW-1:0]        g_raw_s;
    logic signed [GW-1:0]        g_eff_s;

    logic                        s2_valid_r;
    logic [SW-1:0]               s2_sig_r;
    logic signed [GW-1:0]        s2_gain_r;

    logic [CHANNELS*PW-1:0]      prod_s;
    logic                        s3_valid_r;
    logic [CHANNELS*PW-1:0]      s3_prod_r;

    logic signed [PW:0]          rnd_s [CHANNELS];
    logic signed [PW:0]          y_s   [CHANNELS];
    logic [SW-1:0]               sat_s;
    logic [CHANNELS-1:0]         clip_s;

    // The whole pipeline moves together; it only freezes when the output is held.
    assign en_s    = !valid_o || ready_i;
    assign ready_o = en_s;

    // S1: capture the accepted beat together with its mode, depth and modulator.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s1_valid_r <= 1'b0;
            s1_sig_r   <= {SW{1'b0}};
            s1_mod_r   <= {MOD_WIDTH{1'b0}};
            s1_mode_r  <= MODE_BYPASS;
            s1_depth_r <= {DEPTH_WIDTH{1'b0}};
        end else if (en_s) begin
            s1_valid_r <= valid_i;
            s1_sig_r   <= signal_i;
            s1_mod_r   <= $signed(modulator_i);
            s1_mode_r  <= mode_i;
            s1_depth_r <= depth_i;
        end else begin
            s1_valid_r <= s1_valid_r;
            s1_sig_r   <= s1_sig_r;
            s1_mod_r   <= s1_mod_r;
            s1_mode_r  <= s1_mode_r;
            s1_depth_r <= s1_depth_r;
        end
    end

    // Gain selection from the captured beat's mode.
    always_comb begin
        g_raw_s   = {GW{1'b0}};
        am_prod_s = AW'(s1_mod_r) * AW'($signed({1'b0, s1_depth_r}));
        case (s1_mode_r)
            MODE_BYPASS: g_raw_s = UNITY;
            MODE_RING:   g_raw_s = GW'(s1_mod_r);
            MODE_AM:     g_raw_s = UNITY + GW'(am_prod_s >>> DEPTH_WIDTH);
            MODE_MUTE:   g_raw_s = {GW{1'b0}};
            default:     g_raw_s = {GW{1'b0}};
        endcase
    end

`ifdef AMP_MOD_SMOOTH_EN
    logic signed [GW-1:0] g_prev_r;
    logic signed [GW:0]   g_diff_s;

    // One-pole smoothing: move 1/2^SMOOTH_SHIFT of the way toward the new gain.
    always_comb begin
        g_diff_s = (GW+1)'(g_raw_s) - (GW+1)'(g_prev_r);
        g_eff_s  = g_prev_r + GW'(g_diff_s >>> SMOOTH_SHIFT);
    end

    // Smoothing state advances only when a real beat leaves S1.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            g_prev_r <= UNITY;
        end else if (en_s && s1_valid_r) begin
            g_prev_r <= g_eff_s;
        end else begin
            g_prev_r <= g_prev_r;
        end
    end
`else
    // Without smoothing the selected gain is used directly.
    always_comb begin
        g_eff_s = g_raw_s;
    end
`endif

    // S2: register the gain alongside the lanes it applies to.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s2_valid_r <= 1'b0;
            s2_sig_r   <= {SW{1'b0}};
            s2_gain_r  <= {GW{1'b0}};
        end else if (en_s) begin
            s2_valid_r <= s1_valid_r;
            s2_sig_r   <= s1_sig_r;
            s2_gain_r  <= g_eff_s;
        end else begin
            s2_valid_r <= s2_valid_r;
            s2_sig_r   <= s2_sig_r;
            s2_gain_r  <= s2_gain_r;
        end
    end

    // Full-width signed product per lane.
    always_comb begin
        prod_s = {(CHANNELS*PW){1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            prod_s[k*PW +: PW] = PW'($signed(s2_sig_r[k*DATA_WIDTH +: DATA_WIDTH])) * PW'(s2_gain_r);
        end
    end

    // S3 input: products waiting for rounding and saturation.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s3_valid_r <= 1'b0;
            s3_prod_r  <= {(CHANNELS*PW){1'b0}};
        end else if (en_s) begin
            s3_valid_r <= s2_valid_r;
            s3_prod_r  <= prod_s;
        end else begin
            s3_valid_r <= s3_valid_r;
            s3_prod_r  <= s3_prod_r;
        end
    end

    // Round half up, then clamp to the sample range and flag clamped lanes.
    always_comb begin
        sat_s  = {SW{1'b0}};
        clip_s = {CHANNELS{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            rnd_s[k] = (PW+1)'($signed(s3_prod_r[k*PW +: PW])) + RND_HALF;
            y_s[k]   = rnd_s[k] >>> FRAC_BITS;
            if (y_s[k] > SAT_MAX) begin
                sat_s[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MAX[DATA_WIDTH-1:0];
                clip_s[k] = 1'b1;
            end else if (y_s[k] < SAT_MIN) begin
                sat_s[k*DATA_WIDTH +: DATA_WIDTH] = SAT_MIN[DATA_WIDTH-1:0];
                clip_s[k] = 1'b1;
            end else begin
                sat_s[k*DATA_WIDTH +: DATA_WIDTH] = y_s[k][DATA_WIDTH-1:0];
                clip_s[k] = 1'b0;
            end
        end
    end

    // Output registers; an invalid slot drives zeros so idle outputs stay clean.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            valid_o  <= 1'b0;
            signal_o <= {SW{1'b0}};
            clip_o   <= {CHANNELS{1'b0}};
        end else if (en_s) begin
            valid_o  <= s3_valid_r;
            signal_o <= s3_valid_r ? sat_s : {SW{1'b0}};
            clip_o   <= s3_valid_r ? clip_s : {CHANNELS{1'b0}};
        end else begin
            valid_o  <= valid_o;
            signal_o <= signal_o;
            clip_o   <= clip_o;
        end
    end

endmodule

// File: tb/tb_amp_modulator_mc.sv
// Directed bench for amp_modulator_mc (default build): vector table, mid-stream reset,
// and a backpressured ramp stream.
module tb_amp_modulator_mc;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] signal_i;
    logic [15:0] modulator_i;
    logic [1:0]  mode_i;
    logic [7:0]  depth_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] signal_o;
    logic [1:0]  clip_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [1:0] mode;
        int         depth;
        int         modv;
        int         s0;
        int         s1;
        int         e0;
        int         e1;
        int         eclip;
        string      nm;
    } vec_t;

    vec_t vecs [12];

    amp_modulator_mc dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .signal_i    (signal_i),
        .modulator_i (modulator_i),
        .mode_i      (mode_i),
        .depth_i     (depth_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .signal_o    (signal_o),
        .clip_o      (clip_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recvd;
        int cyc;
        bit stall;
        logic [31:0] last_sig;

        vecs[0]  = '{2'b00,   0,   -77,  1000, -1000,  1000, -1000, 0, "bypass"};
        vecs[1]  = '{2'b01,   0,   128, 16384, -16384, 8192, -8192, 0, "ring_half"};
        vecs[2]  = '{2'b01,   0,  -256, 16384,   100, -16384, -100, 0, "ring_neg_unity"};
        vecs[3]  = '{2'b01,   0,     0, 16384,  -555,     0,     0, 0, "ring_zero"};
        vecs[4]  = '{2'b10, 128,   256,  1000, -1000,  1500, -1500, 0, "am_depth128"};
        vecs[5]  = '{2'b10,   0,   256,  1000,     7,  1000,     7, 0, "am_depth0"};
        vecs[6]  = '{2'b11, 200,  1234,  1000,    -5,     0,     0, 0, "mute"};
        vecs[7]  = '{2'b01,   0,   512, 32767, -32768, 32767, -32768, 3, "sat_both"};
        vecs[8]  = '{2'b01,   0,   512,   100,    -3,   200,    -6, 0, "sat_none"};
        vecs[9]  = '{2'b01,   0,     1,   128,  -128,     1,     0, 0, "round_half_up"};
        vecs[10] = '{2'b10, 255,  -256,   256, -1000,     1,    -4, 0, "am_neg_mod"};
        vecs[11] = '{2'b10,   1,    -1,   256,     0,   255,     0, 0, "am_arith_shift"};

        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        signal_i = 32'd0; modulator_i = 16'd0; mode_i = 2'b00; depth_i = 8'd0;

        // Reset held for 5 cycles with random stimulus.
        for (int c = 0; c < 5; c++) begin
            valid_i     = 1'($urandom_range(0, 1));
            ready_i     = 1'($urandom_range(0, 1));
            signal_i    = $urandom;
            modulator_i = 16'($urandom);
            mode_i      = 2'($urandom_range(0, 3));
            depth_i     = 8'($urandom);
            @(posedge clk_i); #1;
            chk("rst_valid_o", int'(valid_o), 0);
            chk("rst_signal_o", int'(signal_o), 0);
            chk("rst_clip_o", int'(clip_o), 0);
            chk("rst_ready_o", int'(ready_o), 1);
        end
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_ready_o", int'(ready_o), 1);

        // Table: one beat each, latency and values checked.
        for (int i = 0; i < 12; i++) begin
            mode_i      = vecs[i].mode;
            depth_i     = 8'(vecs[i].depth);
            modulator_i = 16'(vecs[i].modv);
            signal_i    = {16'(vecs[i].s1), 16'(vecs[i].s0)};
            valid_i     = 1'b1;
            @(posedge clk_i); #1;
            valid_i = 1'b0;
            @(posedge clk_i); #1;
            @(posedge clk_i); #1;
            chk({vecs[i].nm, "_early_valid"}, int'(valid_o), 0);
            @(posedge clk_i); #1;
            chk({vecs[i].nm, "_valid"}, int'(valid_o), 1);
            chk({vecs[i].nm, "_lane0"}, int'($signed(signal_o[15:0])), vecs[i].e0);
            chk({vecs[i].nm, "_lane1"}, int'($signed(signal_o[31:16])), vecs[i].e1);
            chk({vecs[i].nm, "_clip"}, int'(clip_o), vecs[i].eclip);
        end

        // Reset mid-stream discards an in-flight beat.
        mode_i = 2'b00; signal_i = {16'd5, 16'd5}; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = 1'b0; rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk_i); #1;
            chk("midrst_no_output", int'(valid_o), 0);
        end

        // Backpressured ramp: 20 beats, ready_i low for 5 cycles mid-stream.
        sent = 0; recvd = 0; cyc = 0; last_sig = 32'd0;
        while (recvd < 20 && cyc < 200) begin
            stall       = (cyc >= 8 && cyc < 13);
            ready_i     = !stall;
            valid_i     = (sent < 20);
            mode_i      = 2'b00;
            depth_i     = 8'd0;
            modulator_i = 16'(sent * 37);
            signal_i    = {16'(-sent), 16'(100 * sent + 1)};
            #1;
            if (stall) begin
                chk("bp_ready_o_low", int'(ready_o), 0);
                chk("bp_valid_held", int'(valid_o), 1);
                if (cyc > 8) begin
                    chk("bp_data_held", int'(signal_o), int'(last_sig));
                end
            end
            if (valid_o && ready_i) begin
                chk("bp_lane0", int'($signed(signal_o[15:0])), 100 * recvd + 1);
                chk("bp_lane1", int'($signed(signal_o[31:16])), -recvd);
                chk("bp_clip", int'(clip_o), 0);
                recvd++;
            end
            last_sig = signal_o;
            if (valid_i && ready_o) begin
                sent++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        valid_i = 1'b0;
        chk("bp_received", recvd, 20);
        chk("bp_sent", sent, 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/amp_modulator_mc.md
# amp_modulator_mc

Multi-channel, pipelined amplitude modulator and the parametrised successor to the single-channel `amp_modulator`. It multiplies `CHANNELS` signed audio lanes by a gain derived from one shared signed modulator sample. The gain depends on a per-beat mode: bypass, ring modulation, depth-controlled AM, or mute. The block uses valid/ready streaming with backpressure and applies rounding and saturation to every lane. It sits between the oscillator/LFO sources and the output mixer.

## Interface
- `DATA_WIDTH`, 16, signal sample width per channel (signed)
- `MOD_WIDTH`, 16, modulator width (signed, Q.`FRAC_BITS`)
- `FRAC_BITS`, 8, modulator fraction bits; 256 = unity at default
- `CHANNELS`, 2, number of signal lanes sharing one modulator
- `DEPTH_WIDTH`, 8, AM depth width (unsigned fraction, full scale = 2^DEPTH_WIDTH)
- `SMOOTH_SHIFT`, 4, gain smoothing shift (used only with `AMP_MOD_SMOOTH_EN`)
- `clk_i`  in  1  single clock; all logic is on its rising edge
- `rst_i`  in  1  reset, synchronous, active-low
- `valid_i`  in  1  input beat valid
- `ready_o`  out  1  block accepts the beat this cycle
- `signal_i`  in  CHANNELS*DATA_WIDTH  packed lanes, lane 0 in the LSBs
- `modulator_i`  in  MOD_WIDTH  shared modulator sample
- `mode_i`  in  2  00 bypass, 01 ring, 10 AM, 11 mute
- `depth_i`  in  DEPTH_WIDTH  AM depth
- `valid_o`  out  1  output beat valid
- `ready_i`  in  1  downstream accepts the output beat
- `signal_o`  out  CHANNELS*DATA_WIDTH  modulated lanes
- `clip_o`  out  CHANNELS  per-lane saturation flag, qualified by `valid_o`

## Operation
- A beat is accepted when `valid_i && ready_o`. `mode_i`, `depth_i` and `modulator_i` are sampled with that beat.
- Gain g is a signed value of MOD_WIDTH+2 bits and is not saturated:
  - bypass: g = 2^FRAC_BITS
  - ring: g = mod
  - AM: g = 2^FRAC_BITS + ((mod*depth) >>> DEPTH_WIDTH)
  - mute: g = 0
- Per lane: p = sig*g, full width DATA_WIDTH+MOD_WIDTH+2.
- Rounding: y = (p + 2^(FRAC_BITS-1)) >>> FRAC_BITS, i.e. round half up.
- Saturation: y is clamped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. `clip_o[k]`=1 exactly when lane k was clamped.
- Pipeline stages:
  - S1 registers the inputs and computes g.
  - S2 performs the multiply.
  - S3 rounds, saturates, and drives the output registers.
- Stall rule: `en = !valid_o || ready_i`. All stages advance only when `en`=1, and `ready_o = en`.
- While stalled, `signal_o`, `clip_o` and `valid_o` hold stable. No beat is dropped or duplicated, and order is preserved.
- Bubbles (valid_i=0) propagate as invalid stages. The data registers of an invalid stage are don't-care, except that the outputs are 0 while `valid_o`=0 after reset.

## Timing
- Reset (`rst_i`=0 at a clock edge) forces `valid_o`=0, `signal_o`=0, `clip_o`=0, clears all stage valids and sets the smoothing state to 2^FRAC_BITS.
- `ready_o` is 1 during reset and on the first cycle after it.
- Reset asserted mid-stream discards all in-flight beats. No output beat appears until a beat is accepted after release.
- Latency: a beat accepted at edge N appears with `valid_o`=1 after edge N+3 when `ready_i` stays 1.
- Throughput is one beat per cycle when `ready_i`=1.
- `ready_o` is combinational from `ready_i` and `valid_o`. There is no combinational path from `valid_i` to `valid_o`.
- A simultaneous accept and output handshake in the same cycle is legal and sustains full rate.
- Mode or depth may change on any beat and takes effect for exactly that beat.

## Configuration
- Macro: `AMP_MOD_SMOOTH_EN`.
- When defined, S1 applies one-pole smoothing to the gain: g_eff = g_prev + ((g - g_prev) >>> SMOOTH_SHIFT). g_prev updates only on accepted beats and is reset to 2^FRAC_BITS. This suppresses zipper noise on mode or modulator steps. Latency is unchanged.
- When undefined, g_eff = g with no smoothing state, and `SMOOTH_SHIFT` is ignored.
- The test plan values below assume the macro is undefined. A separate smoothing run checks bypass→mute: successive outputs for sig=16384 decay by 1/16 of the remaining gain per beat (15360, 14400, …).

## Test plan
- Reset: hold `rst_i`=0 for 5 cycles with random inputs -> `valid_o`=0, `signal_o`=0, `clip_o`=0, `ready_o`=1. First output appears 3 cycles after the first accepted beat.
- Bypass: mode 00, lanes {1000, -1000}, mod=-77 -> `signal_o`={1000, -1000}, clip=00, latency 3.
- Ring: mode 01, sig=16384 with mod=128 -> 8192. mod=-256 -> -16384. mod=0 -> 0.
- AM: mode 10, depth=128, mod=256, sig=1000 -> g=384, out 1500. depth=0 -> out 1000. Mute with sig=1000 -> 0.
- Saturation: ring, mod=512, lanes {32767, -32768} -> {32767, -32768}, clip=11. With sig=100 in the same setup -> 200, clip=0.
- Backpressure: stream 20 consecutive ramp beats and drop `ready_i` for 5 cycles mid-stream -> outputs hold stable while stalled, `ready_o`=0 during the stall, all 20 results arrive in order with none lost.
